// File: rtl/drm_data_arb_pkg.sv
// drm_data_arb_pkg
// Purpose : Shared constants, tag-pipe entry type and one-hot decode helper for the
//           drm_data arbiter.
// Ports   : none (package)
package drm_data_arb_pkg;

    localparam int unsigned DEF_N_REQ      = 2;
    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_RD_LAT     = 2;
    localparam int unsigned MAX_N_REQ      = 4;
    localparam int unsigned IDX_W          = 2;

    // One stage of the read-response pipe: requester tag plus forward-select flag.
    typedef struct packed {
        logic                 fwd;
        logic [MAX_N_REQ-1:0] tag;
    } tag_entry_t;

    function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_N_REQ-1:0] i_oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_N_REQ); i++) begin
            if (i_oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/drm_data_rr_arb.sv
// drm_data_rr_arb
// Purpose : Combinational round-robin grant over an eligible vector. The first eligible
//           requester at or after the pointer wins; the pointer moves past the winner.
// Ports   : i_clk      clock
//           i_rst_n    synchronous active-low reset (pointer -> 0)
//           i_eligible requesters competing this cycle
//           o_grant    one-hot grant (all zero when nothing is eligible)
module drm_data_rr_arb #(
    parameter int unsigned N_REQ = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_eligible,
    output logic [N_REQ-1:0] o_grant
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_next_ptr;
    logic             w_xfer;

    // The eligible vector already includes req_valid and ready equals the grant, so any
    // grant is a completed transfer.
    always_comb begin
        o_grant    = '0;
        w_xfer     = 1'b0;
        w_next_ptr = r_ptr;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (!w_xfer && i_eligible[(int'(r_ptr) + k) % int'(N_REQ)]) begin
                o_grant[(int'(r_ptr) + k) % int'(N_REQ)] = 1'b1;
                w_xfer     = 1'b1;
                w_next_ptr = PTR_W'((int'(r_ptr) + k + 1) % int'(N_REQ));
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/drm_data_arb.sv
// drm_data_arb
// Purpose : Shares one drm_data simple-dual-port RAM between N_REQ requesters. Write and
//           read ports are arbitrated independently (round-robin), so one write and one
//           read can issue per cycle. Read data returns in order with a one-hot tag.
// Ports   : i_clk, i_rst_n (synchronous, active-low)
//           i_req_valid/i_req_we/i_req_addr/i_req_wdata  packed requests, req 0 in LSBs
//           o_req_ready                                  accept strobe per requester
//           o_rsp_valid/o_rsp_rdata                      one-hot response, 1 cycle
//           o_ram_wr_en/_wr_addr/_wr_data/_wr_byte_en    registered RAM write port
//           o_ram_rd_addr, i_ram_rd_data                 RAM read port
// Config  : DRM_ARB_WR_FWD_EN - forward write data to a same-cycle same-address read.
module drm_data_arb
    import drm_data_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = DEF_N_REQ,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RD_LAT     = DEF_RD_LAT
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ-1:0]           i_req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_wdata,
    output logic [N_REQ-1:0]           o_req_ready,
    output logic [N_REQ-1:0]           o_rsp_valid,
    output logic [DATA_WIDTH-1:0]      o_rsp_rdata,
    output logic                       o_ram_wr_en,
    output logic [ADDR_WIDTH-1:0]      o_ram_wr_addr,
    output logic [DATA_WIDTH-1:0]      o_ram_wr_data,
    output logic                       o_ram_wr_byte_en,
    output logic [ADDR_WIDTH-1:0]      o_ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]      i_ram_rd_data
);

    logic [N_REQ-1:0]     w_wr_elig;
    logic [N_REQ-1:0]     w_rd_elig;
    logic [N_REQ-1:0]     w_wr_grant;
    logic [N_REQ-1:0]     w_rd_grant;
    logic [MAX_N_REQ-1:0] w_wr_oh;
    logic [MAX_N_REQ-1:0] w_rd_oh;
    logic [IDX_W-1:0]     w_wr_idx;
    logic [IDX_W-1:0]     w_rd_idx;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_fwd;
    tag_entry_t            w_rsp;
    logic                  w_unused_rsp;

    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    // Stage k holds the tag of the read whose address hit the RAM k cycles ago.
    tag_entry_t            r_tag_pipe [0:RD_LAT];

    // Gating eligibility with reset keeps ready low and both pointers still during reset.
    assign w_wr_elig = i_req_valid &  i_req_we & {N_REQ{i_rst_n}};
    assign w_rd_elig = i_req_valid & ~i_req_we & {N_REQ{i_rst_n}};

    drm_data_rr_arb #(
        .N_REQ(N_REQ)
    ) u_wr_arb (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_eligible (w_wr_elig),
        .o_grant    (w_wr_grant)
    );

    drm_data_rr_arb #(
        .N_REQ(N_REQ)
    ) u_rd_arb (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_eligible (w_rd_elig),
        .o_grant    (w_rd_grant)
    );

    assign o_req_ready = w_wr_grant | w_rd_grant;

    always_comb begin
        w_wr_oh                = '0;
        w_rd_oh                = '0;
        w_wr_oh[N_REQ-1:0]     = w_wr_grant;
        w_rd_oh[N_REQ-1:0]     = w_rd_grant;
        w_wr_idx               = onehot2idx(w_wr_oh);
        w_rd_idx               = onehot2idx(w_rd_oh);
        w_wr_addr = i_req_addr[int'(w_wr_idx)*int'(ADDR_WIDTH) +: ADDR_WIDTH];
        w_rd_addr = i_req_addr[int'(w_rd_idx)*int'(ADDR_WIDTH) +: ADDR_WIDTH];
        w_wr_data = i_req_wdata[int'(w_wr_idx)*int'(DATA_WIDTH) +: DATA_WIDTH];
    end

`ifdef DRM_ARB_WR_FWD_EN
    logic [DATA_WIDTH-1:0] r_fwd_data [0:RD_LAT];

    // Same-cycle write and read to one address: the RAM would return old data, so the
    // write data rides alongside the tag and replaces the RAM result.
    assign w_fwd = (|w_wr_grant) & (|w_rd_grant) & (w_wr_addr == w_rd_addr);

    always_ff @(posedge i_clk) begin
        r_fwd_data[0] <= w_wr_data;
        for (int k = 1; k <= int'(RD_LAT); k++) begin
            r_fwd_data[k] <= r_fwd_data[k-1];
        end
    end
`else
    assign w_fwd = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_addr <= '0;
            for (int k = 0; k <= int'(RD_LAT); k++) begin
                r_tag_pipe[k] <= '0;
            end
        end else begin
            r_wr_en <= |w_wr_grant;
            if (|w_wr_grant) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= w_wr_data;
            end
            if (|w_rd_grant) begin
                r_rd_addr <= w_rd_addr;
            end
            r_tag_pipe[0] <= '{fwd: w_fwd, tag: w_rd_oh};
            for (int k = 1; k <= int'(RD_LAT); k++) begin
                r_tag_pipe[k] <= r_tag_pipe[k-1];
            end
        end
    end

    assign o_ram_wr_en      = r_wr_en;
    assign o_ram_wr_byte_en = r_wr_en;
    assign o_ram_wr_addr    = r_wr_addr;
    assign o_ram_wr_data    = r_wr_data;
    assign o_ram_rd_addr    = r_rd_addr;

    assign w_rsp        = r_tag_pipe[RD_LAT];
    // Upper tag bits beyond N_REQ and, without forwarding, the fwd flag are never read.
    assign w_unused_rsp = ^w_rsp;

    // Responses are masked during reset so reads in flight never surface.
    assign o_rsp_valid = w_rsp.tag[N_REQ-1:0] & {N_REQ{i_rst_n}};

    always_comb begin
        o_rsp_rdata = '0;
        if (|o_rsp_valid) begin
`ifdef DRM_ARB_WR_FWD_EN
            o_rsp_rdata = w_rsp.fwd ? r_fwd_data[RD_LAT] : i_ram_rd_data;
`else
            o_rsp_rdata = i_ram_rd_data;
`endif
        end
    end

endmodule
